// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-line bus bundle for mem_bus_arbiter.
// slave is the arbiter's view; master is the requester/line-array side.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 2
);
  localparam int unsigned LINES = 2 ** ADDR_W;

  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [7:0]        wdata_a;
  logic [7:0]        wdata_b;
  logic              ack_a;
  logic              ack_b;
  logic [7:0]        rdata;
  logic              busy;
  logic [LINES-1:0]  line_select;
  logic              read_enable;
  logic              write_enable;
  logic [7:0]        mem_in;
  logic [7:0]        mem_out;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_out,
    output ack_a, ack_b, rdata, busy, line_select, read_enable, write_enable, mem_in
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_out,
    input  ack_a, ack_b, rdata, busy, line_select, read_enable, write_enable, mem_in
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin controller sharing one bank of byte-wide lines.
// Each transaction runs IDLE -> SETUP -> ACCESS -> ACK; all outputs registered.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);
  localparam int unsigned LINES = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  state_t            state;
  port_t             ptr;
  port_t             owner;
  logic              owner_we;

  port_t             win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0]        win_wdata;

  // Arbitration: a lone requester wins, a tie is broken by the pointer
  always_comb begin
    win       = PORT_A;
    win_we    = bus.we_a;
    win_addr  = bus.addr_a;
    win_wdata = bus.wdata_a;
    if (!(bus.req_a && (!bus.req_b || ptr == PORT_A))) begin
      win       = PORT_B;
      win_we    = bus.we_b;
      win_addr  = bus.addr_b;
      win_wdata = bus.wdata_b;
    end
  end

  // Transaction FSM; line_select and mem_in double as the latched addr/wdata
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      ptr              <= PORT_A;
      owner            <= PORT_A;
      owner_we         <= 1'b0;
      bus.ack_a        <= 1'b0;
      bus.ack_b        <= 1'b0;
      bus.rdata        <= '0;
      bus.busy         <= 1'b0;
      bus.line_select  <= '0;
      bus.read_enable  <= 1'b0;
      bus.write_enable <= 1'b0;
      bus.mem_in       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            owner           <= win;
            owner_we        <= win_we;
            bus.line_select <= LINES'(1) << win_addr;
            bus.mem_in      <= win_wdata;
            bus.busy        <= 1'b1;
            state           <= SETUP;
          end
        end
        SETUP: begin
          bus.write_enable <= owner_we;
          bus.read_enable  <= !owner_we;
          state            <= ACCESS;
        end
        ACCESS: begin
          bus.write_enable <= 1'b0;
          bus.read_enable  <= 1'b0;
          bus.line_select  <= '0;
          if (!owner_we) begin
            bus.rdata <= bus.mem_out;
          end
          bus.ack_a <= (owner == PORT_A);
          bus.ack_b <= (owner == PORT_B);
          state     <= ACK;
        end
        ACK: begin
          bus.ack_a <= 1'b0;
          bus.ack_b <= 1'b0;
          bus.busy  <= 1'b0;
          ptr       <= (owner == PORT_A) ? PORT_B : PORT_A;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 4-line bank.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(2)) bus ();

  mem_bus_arbiter #(.ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory lines: drive the shared bus only while selected for a read
  logic [7:0] lines [4] = '{default: 8'h00};
  logic [7:0] rd_line;
  always_comb begin
    rd_line = '0;
    for (int i = 0; i < 4; i++) if (bus.line_select[i]) rd_line = lines[i];
  end
  assign bus.mem_out = (bus.read_enable && (bus.line_select != '0)) ? rd_line : 8'hzz;
  always @(posedge clk)
    if (bus.write_enable)
      for (int i = 0; i < 4; i++) if (bus.line_select[i]) lines[i] <= bus.mem_in;

  int checks = 0;
  int passes = 0;
  logic [7:0] ref_mem [4] = '{default: 8'h00};
  logic [7:0] last_rdata = 8'h00;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Bus invariants checked every cycle outside reset
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("excl_enables", 32'(bus.read_enable & bus.write_enable), 0);
      check("onehot0_select", 32'($onehot0(bus.line_select)), 1);
    end
  end

  task automatic drive_port(bit use_b, bit req, bit we, logic [1:0] addr, logic [7:0] wdata);
    if (!use_b) begin
      bus.req_a = req; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata;
    end else begin
      bus.req_b = req; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_port(0, 0, 0, 2'd0, 8'h00);
    drive_port(1, 0, 0, 2'd0, 8'h00);
    reset = 1'b0;
    #1;
    check("rst_acks", {bus.ack_a, bus.ack_b}, 0);
    check("rst_busy_en", {bus.busy, bus.read_enable, bus.write_enable}, 0);
    check("rst_select", bus.line_select, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_mem_in", bus.mem_in, 0);
    @(negedge clk);
    reset = 1'b1;
    last_rdata = 8'h00;
  endtask

  // One isolated transaction with per-cycle checks; starts and ends at a negedge in IDLE
  task automatic single_txn(string tag, bit use_b, bit we, logic [1:0] addr,
                            logic [7:0] wdata, logic [7:0] exp_rdata);
    logic [3:0] sel;
    sel = 4'b0001 << addr;
    drive_port(use_b, 1, we, addr, wdata);
    @(negedge clk);
    check({tag, " setup_busy"}, bus.busy, 1);
    check({tag, " setup_sel"}, bus.line_select, sel);
    check({tag, " setup_en"}, {bus.read_enable, bus.write_enable}, 0);
    check({tag, " setup_mem_in"}, bus.mem_in, wdata);
    @(negedge clk);
    check({tag, " access_sel"}, bus.line_select, sel);
    check({tag, " access_en"}, {bus.read_enable, bus.write_enable}, {!we, we});
    check({tag, " access_ack"}, {bus.ack_a, bus.ack_b}, 0);
    @(negedge clk);
    check({tag, " ack"}, {bus.ack_a, bus.ack_b}, use_b ? 2'b01 : 2'b10);
    check({tag, " rdata"}, bus.rdata, exp_rdata);
    check({tag, " ack_sel_en"}, {bus.line_select, bus.read_enable, bus.write_enable}, 0);
    check({tag, " ack_mem_in"}, bus.mem_in, wdata);
    drive_port(use_b, 0, we, addr, wdata);
    @(negedge clk);
    check({tag, " idle"}, {bus.busy, bus.ack_a, bus.ack_b}, 0);
    if (we) ref_mem[addr] = wdata;
    else last_rdata = exp_rdata;
  endtask

  typedef struct {
    bit         use_b;
    bit         we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t       vecs [9];
  int         ack_a_cyc;
  int         ack_b_cyc;
  logic [7:0] b_rdata;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  bit         r_b;
  bit         r_we;
  logic [1:0] r_addr;
  logic [7:0] r_data;

  initial begin
    reset = 1'b0;
    drive_port(0, 0, 0, 2'd0, 8'h00);
    drive_port(1, 0, 0, 2'd0, 8'h00);

    vecs[0] = '{0, 1, 2'd2, 8'h5A, 8'h00};
    vecs[1] = '{1, 0, 2'd2, 8'h00, 8'h5A};
    vecs[2] = '{1, 1, 2'd0, 8'h3C, 8'h5A};
    vecs[3] = '{0, 1, 2'd3, 8'h96, 8'h5A};
    vecs[4] = '{0, 0, 2'd0, 8'h00, 8'h3C};
    vecs[5] = '{1, 0, 2'd3, 8'h00, 8'h96};
    vecs[6] = '{0, 0, 2'd1, 8'h00, 8'h00};
    vecs[7] = '{1, 1, 2'd1, 8'hE7, 8'h00};
    vecs[8] = '{0, 0, 2'd1, 8'h00, 8'hE7};

    apply_reset();
    foreach (vecs[i])
      single_txn($sformatf("vec%0d", i), vecs[i].use_b, vecs[i].we, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_rdata);

    // Contention: simultaneous requests, A wins after reset
    apply_reset();
    ack_a_cyc = -1; ack_b_cyc = -1; b_rdata = 8'h00;
    drive_port(0, 1, 1, 2'd0, 8'h11);
    drive_port(1, 1, 0, 2'd0, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.ack_a) begin
        if (ack_a_cyc < 0) ack_a_cyc = c;
        bus.req_a = 1'b0;
      end
      if (bus.ack_b) begin
        if (ack_b_cyc < 0) ack_b_cyc = c;
        b_rdata = bus.rdata;
        bus.req_b = 1'b0;
      end
    end
    check("cont_ack_a_cycle", ack_a_cyc, 3);
    check("cont_ack_b_cycle", ack_b_cyc, 7);
    check("cont_b_rdata", b_rdata, 8'h11);
    ref_mem[0] = 8'h11;

    // Fairness: both hold requests for 8 transactions
    apply_reset();
    exp_a = ref_mem[2];
    exp_b = ref_mem[0];
    drive_port(0, 1, 0, 2'd2, 8'h00);
    drive_port(1, 1, 0, 2'd0, 8'h00);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      check($sformatf("fair_busy c%0d", c), bus.busy, (c % 4) != 0);
      check($sformatf("fair_ack_a c%0d", c), bus.ack_a, (c % 8) == 3);
      check($sformatf("fair_ack_b c%0d", c), bus.ack_b, (c % 8) == 7);
      if ((c % 8) == 3) check($sformatf("fair_rdata_a c%0d", c), bus.rdata, exp_a);
      if ((c % 8) == 7) check($sformatf("fair_rdata_b c%0d", c), bus.rdata, exp_b);
      if (c == 31) begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
      end
    end
    last_rdata = exp_b;

    // Input stability: A's fields change during SETUP
    drive_port(0, 1, 1, 2'd1, 8'hC3);
    @(negedge clk);
    check("stab_setup_sel", bus.line_select, 4'b0010);
    check("stab_setup_mem_in", bus.mem_in, 8'hC3);
    bus.wdata_a = 8'hFF;
    bus.addr_a  = 2'd3;
    @(negedge clk);
    check("stab_access_sel", bus.line_select, 4'b0010);
    check("stab_access_we", bus.write_enable, 1);
    check("stab_access_mem_in", bus.mem_in, 8'hC3);
    @(negedge clk);
    check("stab_ack_a", bus.ack_a, 1);
    bus.req_a = 1'b0;
    @(negedge clk);
    check("stab_line1", lines[1], 8'hC3);
    check("stab_line3", lines[3], ref_mem[3]);
    ref_mem[1] = 8'hC3;

    // Reset asserted during the ACCESS cycle of a read
    drive_port(0, 1, 0, 2'd3, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("rmid_access_re", bus.read_enable, 1);
    #1 reset = 1'b0;
    #1;
    check("rmid_re_drop", bus.read_enable, 0);
    check("rmid_sel_drop", bus.line_select, 0);
    check("rmid_busy_drop", bus.busy, 0);
    bus.req_a = 1'b0;
    @(negedge clk);
    check("rmid_no_ack", {bus.ack_a, bus.ack_b}, 0);
    check("rmid_rdata", bus.rdata, 0);
    reset = 1'b1;
    last_rdata = 8'h00;
    @(negedge clk);
    check("rmid_still_idle", {bus.busy, bus.ack_a, bus.ack_b}, 0);
    single_txn("after_rst", 1, 0, 2'd3, 8'h00, ref_mem[3]);

    // Random mix against the reference copy of the lines
    for (int i = 0; i < 200; i++) begin
      r_b    = 1'($urandom_range(0, 1));
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 2'($urandom_range(0, 3));
      r_data = 8'($urandom);
      single_txn($sformatf("rand%0d", i), r_b, r_we, r_addr, r_data,
                 r_we ? last_rdata : ref_mem[r_addr]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port round-robin controller that shares one bank of single-byte memory lines on a common tri-stated 8-bit bus between requesters A and B. It sits between the requesters and the line array. It latches one request at a time, drives the one-hot line select, and issues a single-cycle read or write enable. It returns read data and a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- ADDR_W, 2, line address width; bank has 2**ADDR_W lines

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req_a / req_b  input  1  request from A / B, held high until matching ack
- we_a / we_b  input  1  1 = write, 0 = read; valid while req high
- addr_a / addr_b  input  ADDR_W  target line
- wdata_a / wdata_b  input  8  write data
- ack_a / ack_b  output  1  one-cycle completion pulse
- rdata  output  8  read result, valid in the ack cycle and held until the next read completes
- busy  output  1  high whenever state is not IDLE
- line_select  output  2**ADDR_W  one-hot line select to the memory lines, all-zero when idle
- read_enable / write_enable  output  1  bank-wide enables
- mem_in  output  8  write data to the lines
- mem_out  input  8  shared tri-state read bus from the lines; Z when no line is driving

## Operation
- FSM states: IDLE, SETUP, ACCESS, ACK; all outputs registered.
- IDLE: if neither request is high, stay.
  - If one request is high, that requester wins.
  - If both are high, the requester selected by the priority pointer wins.
  - Latch the winner id, we, addr and wdata, then go to SETUP.
- SETUP:
  - line_select = one-hot(latched addr).
  - mem_in = latched wdata.
  - Both enables stay 0.
  - Next state is ACCESS.
- ACCESS:
  - Hold line_select and mem_in.
  - Assert write_enable (if we=1) or read_enable (if we=0) for exactly this cycle.
  - Write: the line captures mem_in on the rising edge that ends ACCESS.
  - Read: rdata <= mem_out on the rising edge that ends ACCESS.
  - Next state is ACK.
- ACK:
  - Enables go to 0 and line_select goes to all-zero.
  - mem_in holds its value.
  - The winner's ack is high for this one cycle.
  - The priority pointer moves to the other requester.
  - Next state is IDLE.
- The priority pointer moves only on a completed transaction and is never updated in IDLE.
- Requests are sampled only in IDLE. Changes to req, we, addr or wdata during SETUP, ACCESS or ACK are ignored. A req that drops mid-transaction does not abort it, and the ack is still issued.
- At most one line_select bit is ever high. read_enable and write_enable are never high together.
- rdata is unchanged by write transactions.

## Timing
- A request sampled at edge N gives:
  - SETUP in cycle N+1.
  - ACCESS in cycle N+2 (enable high).
  - ACK in cycle N+3 (ack high).
  - IDLE in cycle N+4.
- Throughput: one transaction per 4 cycles.
- A requester must drop req in the cycle after its ack. If req is still high in IDLE, the controller treats it as a new request.
- With both requesters continuously requesting, grants alternate A, B, A, B.
- Reset (reset=0), asynchronous:
  - State goes to IDLE and the priority pointer to A.
  - ack_a, ack_b, busy, read_enable, write_enable and line_select are all 0.
  - rdata = 8'h00 and mem_in = 8'h00.
- Reset mid-transaction: the enables drop immediately, no ack is issued, and the transaction is lost. A write aborted during ACCESS may or may not have reached the line.
- After reset release, the first edge with req high starts a transaction normally.

## Test plan
- Reset then write: reset low, then high. A writes 8'h5A to line 2.
  - Required: line_select=4'b0100 in SETUP and ACCESS.
  - Required: write_enable high for exactly 1 cycle, ack_a 3 cycles after sampling.
  - Read-back by B returns rdata=8'h5A together with ack_b.
- Contention: req_a and req_b rise on the same edge after reset.
  - A writes 8'h11 to line 0, B reads line 0.
  - Required: A is served first (ack_a), then B.
  - Required: B's rdata is 8'h11 and B's ack is 4 cycles after A's ack.
- Fairness: both requesters hold req continuously for 8 transactions.
  - Required: acks alternate A,B,A,B,… with no two consecutive acks to the same port.
  - Required: busy stays high except the single IDLE cycle between transactions.
- Input stability: A starts a write of 8'hC3 to line 1.
  - During SETUP, change wdata_a to 8'hFF and addr_a to 3.
  - Required: line 1 receives 8'hC3, line 3 is unchanged, and line_select never shows bit 3.
- Reset mid-op: assert reset during the ACCESS cycle of a read.
  - Required: read_enable, line_select and busy go to 0 before the next clock edge.
  - Required: no ack is issued, rdata=8'h00, and the next request completes normally.
- Exclusivity check: a random mix of 200 read/write transactions from both ports.
  - Required: read_enable and write_enable are never both high.
  - Required: line_select is always one-hot or zero.
  - Required: read data matches a reference model of the lines.
